// File: rtl/filter_rx.sv
// filter_rx: undoes a Filter stage's left shift and data/parity skew, buffering recovered words in a registered FIFO.
// Optional drop counter built only when FILTER_RX_DROPCNT_EN is defined; otherwise io_drops reads 8'h00.
module filter_rx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_x_data,
  input  logic             io_x_valid,
  input  logic             io_x_parity,
  output logic [WIDTH-1:0] io_y_data,
  output logic             io_y_valid,
  output logic             io_y_parity,
  input  logic             io_y_ready,
  output logic             io_overflow,
  output logic [7:0]       io_drops
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH:0] mem_q [DEPTH];
  logic [WIDTH:0] head_q, head_d, word;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic par_q, vld_q, vld_d, ov_q, full, push, pop, drop;
  // Entry layout: {recovered word, recovered parity}
  assign word = {par_q, io_x_data[WIDTH-1:1], io_x_data[0]};
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop = vld_q & io_y_ready;
  assign push = io_x_valid & (!full | pop);
  assign drop = io_x_valid & full & !pop;
  assign wr_d = wr_q + {{AW{1'b0}}, push};
  assign rd_d = rd_q + {{AW{1'b0}}, pop};
  assign vld_d = wr_d != rd_d;
  // New head bypasses the array when it is the word being written this cycle
  assign head_d = !vld_d ? head_q : (push && wr_q == rd_d) ? word : mem_q[rd_d[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= word;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      par_q <= 1'b0;
      vld_q <= 1'b0;
      ov_q <= 1'b0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      par_q <= io_x_parity;
      vld_q <= vld_d;
      ov_q <= ov_q | drop;
      head_q <= head_d;
    end
`ifdef FILTER_RX_DROPCNT_EN
  logic [7:0] drops_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) drops_q <= 8'h00;
    else if (drop && drops_q != 8'hFF) drops_q <= drops_q + 8'd1;
  assign io_drops = drops_q;
`else
  assign io_drops = 8'h00;
`endif
  assign io_y_data = head_q[WIDTH:1];
  assign io_y_parity = head_q[0];
  assign io_y_valid = vld_q;
  assign io_overflow = ov_q;
endmodule
